// File: rtl/scan_sequencer_if.sv
// Channel-scan bundle between a scan controller (master) and the sequencer (slave).
// The slave drives the select/enable pair that feeds the 2-to-4 active-low decoder.
interface scan_sequencer_if;
    logic       run;
    logic [3:0] mask;
    logic [1:0] sel;
    logic       en_n;
    logic       active;
    logic       frame_done;

    modport master (
        output run,
        output mask,
        input  sel,
        input  en_n,
        input  active,
        input  frame_done
    );

    modport slave (
        input  run,
        input  mask,
        output sel,
        output en_n,
        output active,
        output frame_done
    );
endinterface

// File: rtl/scan_sequencer.sv
// Time-multiplexed channel scanner for a 2-to-4 active-low decoder: blanks the decoder
// around every select change, skips masked channels and pulses frame_done per frame.
module scan_sequencer #(
    parameter int unsigned DWELL = 8,
    parameter int unsigned BLANK = 2,
    parameter int unsigned CNT_W = 16
) (
    input logic            clk,
    input logic            rst,
    scan_sequencer_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StBlank, StDwell} state_e;

    localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] BlankLast = CNT_W'(BLANK - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       tgt_q, tgt_d;
    logic             en_n_q, en_n_d;
    logic             active_q, active_d;
    logic             done_q, done_d;

    logic [1:0]       lowest;
    logic [1:0]       next_up;
    logic             has_above;

    // Channel search: lowest enabled channel, and the next enabled one above sel (wrapping).
    always_comb begin
        lowest = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.mask[i]) lowest = 2'(i);
        end
        next_up   = lowest;
        has_above = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            if (bus.mask[i] && (i > int'(sel_q))) begin
                next_up   = 2'(i);
                has_above = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        tgt_d   = tgt_q;
        en_n_d  = en_n_q;
        done_d  = 1'b0;
        case (state_q)
            StIdle: begin
                en_n_d = 1'b1;
                cnt_d  = '0;
                if (bus.run && (bus.mask != 4'b0000)) begin
                    state_d = StBlank;
                    tgt_d   = lowest;
                end
            end
            StBlank: begin
                en_n_d = 1'b1;
                if (!bus.run) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == BlankLast) begin
                    state_d = StDwell;
                    en_n_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    // BLANK >= 2, so the select update never shares an edge with en_n falling.
                    if (cnt_q == '0) sel_d = tgt_q;
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDwell: begin
                en_n_d = 1'b0;
                if (cnt_q == DwellLast) begin
                    en_n_d  = 1'b1;
                    cnt_d   = '0;
                    tgt_d   = next_up;
                    done_d  = bus.mask[sel_q] && !has_above;
                    state_d = (bus.run && (bus.mask != 4'b0000)) ? StBlank : StIdle;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
                en_n_d  = 1'b1;
                cnt_d   = '0;
            end
        endcase
        active_d = (state_d != StIdle);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            sel_q    <= 2'b00;
            tgt_q    <= 2'b00;
            en_n_q   <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            tgt_q    <= tgt_d;
            en_n_q   <= en_n_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.en_n       = en_n_q;
    assign bus.active     = active_q;
    assign bus.frame_done = done_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: expected channel/frame_done per dwell are queued as
// stimulus is applied and popped as each en_n-low window appears.
module tb_scan_sequencer;
    localparam int unsigned DWELL = 8;
    localparam int unsigned BLANK = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    scan_sequencer_if bus ();

    scan_sequencer #(
        .DWELL(DWELL),
        .BLANK(BLANK),
        .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] sel;
        logic       done;
    } exp_t;

    exp_t exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [3:0] decode(input logic en_n, input logic [1:0] s);
        return en_n ? 4'hF : ~(4'b0001 << s);
    endfunction

    task automatic push(input logic [1:0] s, input logic d);
        exp_t e;
        e.sel  = s;
        e.done = d;
        exp_q.push_back(e);
    endtask

    // Waits (bounded) for en_n low starting from the current negedge sample.
    task automatic wait_low(input int exp_gap, output exp_t e);
        int gap = 0;
        logic [3:0] want;
        while (bus.en_n === 1'b1 && gap < 100) begin
            gap++;
            @(negedge clk);
        end
        if (exp_gap > 0) check("gap_len", gap, exp_gap);
        if (exp_q.size() == 0) begin
            e.sel  = 2'd0;
            e.done = 1'b0;
            total++;
            bad++;
            $error("FAIL scoreboard: observed=empty expected=entry");
        end else begin
            e = exp_q.pop_front();
        end
        want = ~(4'b0001 << e.sel);
        check("sel", bus.sel, e.sel);
        check("decoder", decode(bus.en_n, bus.sel), want);
        check("active_run", bus.active, 1);
    endtask

    task automatic dwell(input int exp_gap, input int drop_at, input int chg_at,
                         input logic [3:0] chg_mask);
        exp_t e;
        int low = 0;
        int fd  = 0;
        wait_low(exp_gap, e);
        while (bus.en_n === 1'b0 && low < 100) begin
            low++;
            if (bus.frame_done === 1'b1) fd++;
            if (low == drop_at) bus.run = 1'b0;
            if (low == chg_at) bus.mask = chg_mask;
            @(negedge clk);
        end
        check("dwell_len", low, DWELL);
        check("done_in_dwell", fd, 0);
        check("frame_done", bus.frame_done, e.done);
    endtask

    // Select must never move while en_n is low on either side of an edge.
    logic [1:0] prev_sel;
    logic       prev_en_n;
    logic       prev_valid = 1'b0;
    logic       rst_hit    = 1'b0;

    always @(posedge rst) rst_hit = 1'b1;

    always @(negedge clk) begin
        if (rst_hit || rst === 1'b1) begin
            prev_valid = 1'b0;
            rst_hit    = 1'b0;
        end else begin
            if (prev_valid && (bus.sel !== prev_sel))
                check("sel_glitch", {prev_en_n, bus.en_n}, 2'b11);
            prev_sel   = bus.sel;
            prev_en_n  = bus.en_n;
            prev_valid = 1'b1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        rst      = 1'b1;
        bus.run  = 1'b0;
        bus.mask = 4'b0000;
        repeat (3) @(negedge clk);
        check("rst_sel", bus.sel, 0);
        check("rst_en_n", bus.en_n, 1);
        check("rst_active", bus.active, 0);
        check("rst_done", bus.frame_done, 0);
        rst = 1'b0;
        @(negedge clk);

        // Full mask: 0,1,2,3,0 with the frame pulse on channel 3.
        bus.mask = 4'b1111;
        bus.run  = 1'b1;
        push(2'd0, 1'b0);
        push(2'd1, 1'b0);
        push(2'd2, 1'b0);
        push(2'd3, 1'b1);
        push(2'd0, 1'b0);
        dwell(BLANK + 1, 0, 0, 4'b0000);
        repeat (4) dwell(BLANK, 0, 0, 4'b0000);

        // Switched during blank; channel 1 was already targeted from the old mask.
        bus.mask = 4'b1010;
        push(2'd1, 1'b0);
        push(2'd3, 1'b1);
        push(2'd1, 1'b0);
        push(2'd3, 1'b1);
        repeat (4) dwell(BLANK, 0, 0, 4'b0000);

        // run dropped in dwell cycle 3: dwell still completes, then idle.
        push(2'd1, 1'b0);
        dwell(BLANK, 3, 0, 4'b0000);
        check("drop_active", bus.active, 0);
        repeat (12) @(negedge clk);
        check("idle_sel", bus.sel, 1);
        check("idle_en_n", bus.en_n, 1);
        check("idle_active", bus.active, 0);

        // Single channel repeats; mask cleared mid-dwell ends the scan.
        bus.mask = 4'b0100;
        bus.run  = 1'b1;
        push(2'd2, 1'b1);
        push(2'd2, 1'b1);
        push(2'd2, 1'b1);
        push(2'd2, 1'b0);
        dwell(BLANK + 1, 0, 0, 4'b0000);
        dwell(BLANK, 0, 0, 4'b0000);
        dwell(BLANK, 0, 0, 4'b0000);
        dwell(BLANK, 0, 4, 4'b0000);
        check("mask0_active", bus.active, 0);
        repeat (12) @(negedge clk);
        check("mask0_en_n", bus.en_n, 1);
        check("mask0_active_late", bus.active, 0);
        check("mask0_sel", bus.sel, 2);

        // Reset in the middle of the channel 1 dwell.
        bus.mask = 4'b0011;
        push(2'd0, 1'b0);
        push(2'd1, 1'b1);
        dwell(BLANK + 1, 0, 0, 4'b0000);
        wait_low(BLANK, e);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("arst_en_n", bus.en_n, 1);
        check("arst_sel", bus.sel, 0);
        check("arst_active", bus.active, 0);
        check("arst_done", bus.frame_done, 0);
        @(negedge clk);
        check("arst_done_held", bus.frame_done, 0);
        check("arst_en_n_held", bus.en_n, 1);
        rst = 1'b0;
        push(2'd0, 1'b0);
        push(2'd1, 1'b1);
        dwell(BLANK + 1, 0, 0, 4'b0000);
        dwell(BLANK, 0, 0, 4'b0000);

        bus.run = 1'b0;
        repeat (20) @(negedge clk);
        check("end_active", bus.active, 0);
        check("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
